// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control inputs, ROM address/data, and captured instruction outputs.
// The master modport is the fetch unit; slave is the surrounding core/ROM side.
interface instr_fetch_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              start;
    logic              stall;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              done;

    modport master (
        input  start, stall, jump_en, jump_addr, rom_data,
        output rom_ce, rom_address, instr, instr_valid, pc, done
    );

    modport slave (
        output start, stall, jump_en, jump_addr, rom_data,
        input  rom_ce, rom_address, instr, instr_valid, pc, done
    );
endinterface

// File: rtl/instr_fetch.sv
// Sequential instruction fetch from a combinational ROM: IDLE/FETCH/DONE control with
// stall, jump redirect and optional wrap at LAST_ADDR; one-cycle address-to-instr latency.
module instr_fetch #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 16,
    parameter int LAST_ADDR = 7,
    parameter int WRAP      = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_p0;
    logic [DATA_W-1:0] instr_p1;
    logic              vld_p1;
    logic              capture;
    logic              redirect;
    logic              at_last;

    // A jump beats a stall; a capture only happens with neither pending.
    assign redirect = (state == FETCH) && bus.jump_en;
    assign capture  = (state == FETCH) && !bus.jump_en && !bus.stall;
    assign at_last  = (pc_p0 == LAST_PC);

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur);
        if (cur == LAST_PC)
            return (WRAP != 0) ? '0 : cur;
        return cur + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start)
                    state_nxt = FETCH;
            end
            FETCH: begin
                if (capture && at_last && (WRAP == 0))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.rom_ce = 1'b0;
        bus.done   = 1'b0;
        unique case (state)
            FETCH:   bus.rom_ce = !bus.stall;
            DONE:    bus.done   = 1'b1;
            default: ;
        endcase
    end

    // Stage p0: fetch address register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pc_p0 <= '0;
        else if (state != FETCH) begin
            if (bus.start)
                pc_p0 <= '0;
        end else if (redirect)
            pc_p0 <= bus.jump_addr;
        else if (capture)
            pc_p0 <= next_pc(pc_p0);
    end

    // Stage p1: captured instruction word and its valid strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= capture;
            if (capture)
                instr_p1 <= bus.rom_data;
        end
    end

    assign bus.rom_address = pc_p0;
    assign bus.pc          = pc_p0;
    assign bus.instr       = instr_p1;
    assign bus.instr_valid = vld_p1;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a WRAP=0 and a WRAP=1 instance share stimulus;
// a reference model queues expected words, monitors pop them on instr_valid.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       jump_en = 1'b0;
    logic [2:0] jump_addr = 3'd0;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(3), .DATA_W(16)) bus0 ();
    instr_fetch_if #(.ADDR_W(3), .DATA_W(16)) bus1 ();

    assign bus0.start     = start;
    assign bus0.stall     = stall;
    assign bus0.jump_en   = jump_en;
    assign bus0.jump_addr = jump_addr;
    assign bus0.rom_data  = 16'hA000 + 16'(bus0.rom_address);
    assign bus1.start     = start;
    assign bus1.stall     = stall;
    assign bus1.jump_en   = jump_en;
    assign bus1.jump_addr = jump_addr;
    assign bus1.rom_data  = 16'hA000 + 16'(bus1.rom_address);

    instr_fetch #(.ADDR_W(3), .DATA_W(16), .LAST_ADDR(7), .WRAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    instr_fetch #(.ADDR_W(3), .DATA_W(16), .LAST_ADDR(7), .WRAP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    logic [2:0]  a_pc[2];
    logic [2:0]  a_addr[2];
    logic        a_done[2];
    logic        a_ce[2];
    logic        a_vld[2];
    logic [15:0] a_instr[2];
    assign a_pc[0] = bus0.pc;             assign a_pc[1] = bus1.pc;
    assign a_addr[0] = bus0.rom_address;  assign a_addr[1] = bus1.rom_address;
    assign a_done[0] = bus0.done;         assign a_done[1] = bus1.done;
    assign a_ce[0] = bus0.rom_ce;         assign a_ce[1] = bus1.rom_ce;
    assign a_vld[0] = bus0.instr_valid;   assign a_vld[1] = bus1.instr_valid;
    assign a_instr[0] = bus0.instr;       assign a_instr[1] = bus1.instr;

    // Reference model: 0 = idle, 1 = fetching, 2 = done
    int          m_state[2];
    logic [2:0]  m_pc[2];
    logic [15:0] m_instr[2];
    logic        m_vld[2];
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_pc[i]    = 3'd0;
            m_instr[i] = 16'h0;
            m_vld[i]   = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("pc", i, 32'(a_pc[i]), 32'(m_pc[i]));
            chk("rom_address", i, 32'(a_addr[i]), 32'(m_pc[i]));
            chk("done", i, 32'(a_done[i]), 32'(m_state[i] == 2));
            chk("rom_ce", i, 32'(a_ce[i]), 32'((m_state[i] == 1) && !stall));
            chk("instr_valid", i, 32'(a_vld[i]), 32'(m_vld[i]));
            chk("instr", i, 32'(a_instr[i]), 32'(m_instr[i]));
        end
    endtask

    task automatic model_step();
        logic [15:0] word;
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 1'b0;
            if (m_state[i] != 1) begin
                if (start) begin
                    m_state[i] = 1;
                    m_pc[i]    = 3'd0;
                end
            end else if (jump_en) begin
                m_pc[i] = jump_addr;
            end else if (!stall) begin
                word       = 16'hA000 + 16'(m_pc[i]);
                m_instr[i] = word;
                m_vld[i]   = 1'b1;
                if (i == 0) q0.push_back(word);
                else        q1.push_back(word);
                if (m_pc[i] == 3'd7) begin
                    if (i == 1) m_pc[i] = 3'd0;
                    else        m_state[i] = 2;
                end else begin
                    m_pc[i] = m_pc[i] + 3'd1;
                end
            end
        end
    endtask

    task automatic step(input logic st, input logic sl, input logic je, input logic [2:0] ja);
        @(negedge clk);
        start     = st;
        stall     = sl;
        jump_en   = je;
        jump_addr = ja;
        #1;
        check_all();
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        start   = 1'b0;
        stall   = 1'b0;
        jump_en = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [15:0] e0;
    logic [15:0] e1;

    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus0.instr_valid === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected dut0: got %0h want none at %0t", bus0.instr, $time);
            end else begin
                e0 = q0.pop_front();
                chk("mon_instr", 0, 32'(bus0.instr), 32'(e0));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus1.instr_valid === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected dut1: got %0h want none at %0t", bus1.instr, $time);
            end else begin
                e1 = q1.pop_front();
                chk("mon_instr", 1, 32'(bus1.instr), 32'(e1));
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Full run to DONE (dut1 wraps instead)
        step(1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0);

        // Stall three cycles at pc=3
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (8) step(0, 0, 0, 0);

        // Jump to 6 at pc=2
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 1, 3'd6);
        repeat (4) step(0, 0, 0, 0);

        // Jump with stall at pc=1
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 3'd4);
        repeat (8) step(0, 0, 0, 0);

        // Asynchronous reset at pc=5, then restart
        step(1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        do_reset();
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // Jump in DONE is ignored
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 1, 3'd2);
        step(0, 0, 0, 0);

        repeat (400) begin
            if ($urandom_range(0, 99) < 2)
                do_reset();
            else
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
        end

        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_empty", 0, 32'(q0.size()), 32'd0);
        chk("queue_empty", 1, 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3, meaning the ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the ROM word width.
REQ-003 The block SHALL have parameter LAST_ADDR, default 7, meaning the final address fetched before halting.
REQ-004 The block SHALL have parameter WRAP, default 0; when 1, the fetch wraps to address 0 instead of halting.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, which begins fetching from address 0 when sampled high in IDLE or DONE.
REQ-008 The block SHALL have port stall, input, 1 bit, which freezes the fetch while high.
REQ-009 The block SHALL have port jump_en, input, 1 bit, which requests a redirect of pc.
REQ-010 The block SHALL have port jump_addr, input, ADDR_W bits, the redirect target.
REQ-011 The block SHALL have port rom_ce, output, 1 bit, the ROM chip enable.
REQ-012 The block SHALL have port rom_address, output, ADDR_W bits, the ROM address.
REQ-013 The block SHALL have port rom_data, input, DATA_W bits, the combinational ROM read data.
REQ-014 The block SHALL have port instr, output, DATA_W bits, the captured instruction word.
REQ-015 The block SHALL have port instr_valid, output, 1 bit, high for exactly one cycle per newly captured word.
REQ-016 The block SHALL have port pc, output, ADDR_W bits, the current fetch address register.
REQ-017 The block SHALL have port done, output, 1 bit, high while in DONE.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DONE; IDLE->FETCH and DONE->FETCH occur on start, with pc loaded to 0.
REQ-019 rom_address SHALL equal pc combinationally; rom_ce SHALL be 1 only in FETCH with stall low, else 0.
REQ-020 In FETCH with stall low and jump_en low, each rising edge SHALL apply instr<=rom_data, set instr_valid to 1, and set pc<=pc+1 (one-cycle latency, address to instr).
REQ-021 In FETCH with jump_en high, the edge SHALL set pc<=jump_addr, instr_valid<=0, and leave instr unchanged (current word discarded); jump_en SHALL take priority over stall.
REQ-022 In FETCH with stall high and jump_en low, pc and instr SHALL hold and instr_valid SHALL be 0.
REQ-023 Capturing at pc==LAST_ADDR SHALL, for WRAP=0, go to DONE with pc held at LAST_ADDR; for WRAP=1, remain in FETCH with pc<=0.
REQ-024 pc arithmetic SHALL be modulo 2^ADDR_W; a jump_addr greater than LAST_ADDR SHALL be accepted and fetched unchanged.
REQ-025 start while in FETCH SHALL be ignored; jump_en in IDLE or DONE SHALL be ignored.
REQ-026 instr_valid SHALL be 0 in IDLE and DONE except on the single cycle after the final capture.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, pc=0, instr=0, instr_valid=0, done=0, rom_ce=0, regardless of clk.
REQ-028 Reset asserted mid-FETCH SHALL abandon the fetch; after release the block SHALL wait in IDLE for start.

Verification (ROM preloaded with mem[i]=16'hA000+i)
REQ-029 Reset, then pulse start -> rom_ce=1; instr = A000..A007 on 8 consecutive cycles with instr_valid high; then done=1, rom_ce=0, pc=7.
REQ-030 stall high for 3 cycles at pc=3 -> pc holds 3, instr holds A002, instr_valid=0, rom_ce=0; then fetch resumes with A003.
REQ-031 jump_en with jump_addr=6 at pc=2 -> word A002 not presented; next captures are A006, A007, then DONE.
REQ-032 jump_en and stall both high at pc=1, jump_addr=4 -> pc=4 on the next edge.
REQ-033 WRAP=1 -> after A007, the next capture is A000 and done stays 0.
REQ-034 reset_n low asynchronously at pc=5 -> outputs zero before the next clk edge; start afterward restarts at A000.
